compare8_result_acc: RTL and testbench

Downstream consumer of the 8-bit magnitude comparator. Accepts one operand pair per handshake together with the comparator's `re` (a>b), `reb` (a<b) and `eq` flags, accumulates per-window statistics, and emits one summary report per window of `WINDOW` samples over a valid/ready output handshake. It provides a cycle-accurate running scoreboard of comparator results for the compare datapath and its bench.

---
 rtl/compare8_pkg.sv | 17 +
 rtl/compare8_result_acc_if.sv | 35 +++
 rtl/compare8_check.sv | 22 ++
 rtl/compare8_result_acc.sv | 133 +++++++++++++
 tb/tb_compare8_result_acc.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/compare8_pkg.sv
// Shared definitions for the compare8 datapath: operand width, accumulator
// state encoding and a small unsigned max helper.
package compare8_pkg;

  localparam int CMP_W = 8;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } acc_state_t;

  function automatic logic [CMP_W-1:0] max2(input logic [CMP_W-1:0] x,
                                            input logic [CMP_W-1:0] y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/compare8_result_acc_if.sv
// Sample-in / report-out handshake bundle for compare8_result_acc.
// The master drives samples and accepts reports; the slave is the accumulator.
interface compare8_result_acc_if #(
  parameter int WINDOW = 16
);
  import compare8_pkg::*;

  localparam int CW = $clog2(WINDOW + 1);

  logic             in_valid;
  logic             in_ready;
  logic [CMP_W-1:0] a;
  logic [CMP_W-1:0] b;
  logic             re;
  logic             reb;
  logic             eq;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    gt_cnt;
  logic [CW-1:0]    lt_cnt;
  logic [CW-1:0]    eq_cnt;
  logic [CMP_W-1:0] max_val;
  logic             err;

  modport master (
    output in_valid, a, b, re, reb, eq, out_ready,
    input  in_ready, out_valid, gt_cnt, lt_cnt, eq_cnt, max_val, err
  );

  modport slave (
    input  in_valid, a, b, re, reb, eq, out_ready,
    output in_ready, out_valid, gt_cnt, lt_cnt, eq_cnt, max_val, err
  );

endinterface

// File: rtl/compare8_check.sv
// Combinational consistency check of comparator flags against the operands:
// bad is high unless exactly one flag is set and it matches a>b / a<b / a==b.
module compare8_check
  import compare8_pkg::*;
(
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  input  logic             re,
  input  logic             reb,
  input  logic             eq,
  output logic             bad
);

  logic one_hot;
  logic agree;

  assign one_hot = ({re, reb, eq} == 3'b100) || ({re, reb, eq} == 3'b010) ||
                   ({re, reb, eq} == 3'b001);
  assign agree   = (re == (a > b)) && (reb == (a < b)) && (eq == (a == b));
  assign bad     = !(one_hot && agree);

endmodule

// File: rtl/compare8_result_acc.sv
// Windowed scoreboard of comparator results: counts re/reb/eq and the running
// max(a,b) over WINDOW samples, then holds one report until it is accepted.
// Optional flag checking is enabled with `define COMPARE8_CHECK_EN.
module compare8_result_acc
  import compare8_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  compare8_result_acc_if.slave bus
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  acc_state_t       state_q, state_d;
  logic [CW-1:0]    smp_q, smp_d;
  logic [CW-1:0]    gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CMP_W-1:0] max_q, max_d;
  logic [CW-1:0]    rgt_q, rgt_d, rlt_q, rlt_d, req_q, req_d;
  logic [CMP_W-1:0] rmax_q, rmax_d;

  logic             accept;
  logic [CW-1:0]    gt_nx, lt_nx, eq_nx;
  logic [CMP_W-1:0] max_nx;

  assign accept = bus.in_valid && (state_q == ACCUM);
  assign gt_nx  = gt_q + CW'(bus.re);
  assign lt_nx  = lt_q + CW'(bus.reb);
  assign eq_nx  = eq_q + CW'(bus.eq);
  assign max_nx = max2(max_q, max2(bus.a, bus.b));

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    max_d   = max_q;
    rgt_d   = rgt_q;
    rlt_d   = rlt_q;
    req_d   = req_q;
    rmax_d  = rmax_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (smp_q == LAST) begin
            // Window complete: publish totals including this sample, restart clean.
            rgt_d   = gt_nx;
            rlt_d   = lt_nx;
            req_d   = eq_nx;
            rmax_d  = max_nx;
            gt_d    = '0;
            lt_d    = '0;
            eq_d    = '0;
            max_d   = '0;
            smp_d   = '0;
            state_d = REPORT;
          end else begin
            gt_d    = gt_nx;
            lt_d    = lt_nx;
            eq_d    = eq_nx;
            max_d   = max_nx;
            smp_d   = smp_q + CW'(1);
          end
        end
      end
      REPORT: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      smp_q   <= '0;
      gt_q    <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      max_q   <= '0;
      rgt_q   <= '0;
      rlt_q   <= '0;
      req_q   <= '0;
      rmax_q  <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      max_q   <= max_d;
      rgt_q   <= rgt_d;
      rlt_q   <= rlt_d;
      req_q   <= req_d;
      rmax_q  <= rmax_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == REPORT);
  assign bus.gt_cnt    = rgt_q;
  assign bus.lt_cnt    = rlt_q;
  assign bus.eq_cnt    = req_q;
  assign bus.max_val   = rmax_q;

`ifdef COMPARE8_CHECK_EN
  logic bad;
  logic err_q;

  compare8_check u_check (
    .a   (bus.a),
    .b   (bus.b),
    .re  (bus.re),
    .reb (bus.reb),
    .eq  (bus.eq),
    .bad (bad)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              err_q <= 1'b0;
    else if (accept && bad) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_compare8_result_acc.sv
// Scoreboard bench for compare8_result_acc: a WINDOW=4 and a WINDOW=1 instance
// share clock/reset; expected reports are queued and checked by monitors.
module tb_compare8_result_acc;

  typedef struct {
    int gt;
    int lt;
    int eq;
    int mx;
  } rep_t;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  rep_t q4[$];
  rep_t q1[$];
  rep_t e4, e1;

  compare8_result_acc_if #(.WINDOW(4)) if4 ();
  compare8_result_acc_if #(.WINDOW(1)) if1 ();

  compare8_result_acc #(.WINDOW(4)) u_dut4 (.clock(clk), .reset(rst), .bus(if4));
  compare8_result_acc #(.WINDOW(1)) u_dut1 (.clock(clk), .reset(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic rep_t mk(input int g, input int l, input int e, input int m);
    rep_t r;
    r.gt = g; r.lt = l; r.eq = e; r.mx = m;
    return r;
  endfunction

  always @(negedge clk) begin
    if (if4.out_valid && if4.out_ready) begin
      if (q4.size() == 0) begin
        chk("w4_unexpected_report", 1, 0);
      end else begin
        e4 = q4.pop_front();
        chk("w4_gt", int'(if4.gt_cnt), e4.gt);
        chk("w4_lt", int'(if4.lt_cnt), e4.lt);
        chk("w4_eq", int'(if4.eq_cnt), e4.eq);
        chk("w4_max", int'(if4.max_val), e4.mx);
      end
    end
    if (if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_report", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("w1_gt", int'(if1.gt_cnt), e1.gt);
        chk("w1_lt", int'(if1.lt_cnt), e1.lt);
        chk("w1_eq", int'(if1.eq_cnt), e1.eq);
        chk("w1_max", int'(if1.max_val), e1.mx);
      end
    end
  end

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic re, input logic reb, input logic eq);
    int n = 0;
    @(negedge clk);
    if4.in_valid = 1'b1; if4.a = a; if4.b = b;
    if4.re = re; if4.reb = reb; if4.eq = eq;
    while (!if4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w4_accept_timeout", n, 0);
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b,
                       input logic re, input logic reb, input logic eq);
    int n = 0;
    @(negedge clk);
    if1.in_valid = 1'b1; if1.a = a; if1.b = b;
    if1.re = re; if1.reb = reb; if1.eq = eq;
    while (!if1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w1_accept_timeout", n, 0);
    @(posedge clk);
    #1 if1.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q4.size() + q1.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra[4];
    logic [7:0] rb[4];
    int g, l, e, m, exp_rdy;

    rst = 1'b1;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.re = 1'b0; if4.reb = 1'b0; if4.eq = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.re = 1'b0; if1.reb = 1'b0; if1.eq = 1'b0;
    if4.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    #12 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", if4.in_ready, 1);
    chk("rst_out_valid", if4.out_valid, 0);
    chk("rst_gt", int'(if4.gt_cnt), 0);
    chk("rst_lt", int'(if4.lt_cnt), 0);
    chk("rst_eq", int'(if4.eq_cnt), 0);
    chk("rst_max", int'(if4.max_val), 0);
    chk("rst_err", if4.err, 0);

    // Basic window; monitor rejects a second report cycle via the empty queue.
    q4.push_back(mk(2, 1, 1, 200));
    send4(10, 5, 1, 0, 0);
    send4(3, 9, 0, 1, 0);
    send4(7, 7, 0, 0, 1);
    send4(200, 1, 1, 0, 0);
    drain();

    // Backpressure: report holds, offered sample waits for the next window.
    if4.out_ready = 1'b0;
    q4.push_back(mk(2, 1, 1, 100));
    send4(1, 2, 0, 1, 0);
    send4(5, 5, 0, 0, 1);
    send4(9, 3, 1, 0, 0);
    send4(100, 50, 1, 0, 0);
    if4.in_valid = 1'b1; if4.a = 250; if4.b = 0; if4.re = 1'b1; if4.reb = 1'b0; if4.eq = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", if4.in_ready, 0);
      chk("stall_out_valid", if4.out_valid, 1);
      chk("stall_gt", int'(if4.gt_cnt), 2);
      chk("stall_max", int'(if4.max_val), 100);
    end
    @(posedge clk);
    #1 if4.out_ready = 1'b1;
    q4.push_back(mk(1, 0, 3, 250));
    send4(250, 0, 1, 0, 0);
    send4(0, 0, 0, 0, 1);
    send4(0, 0, 0, 0, 1);
    send4(0, 0, 0, 0, 1);
    drain();

    // Reset mid-window discards the partial counts.
    send4(10, 5, 1, 0, 0);
    send4(3, 9, 0, 1, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", if4.in_ready, 1);
    chk("midrst_out_valid", if4.out_valid, 0);
    q4.push_back(mk(0, 0, 4, 0));
    repeat (4) send4(0, 0, 0, 0, 1);
    drain();

    // WINDOW=1 with continuous valid: in_ready alternates, one report per sample.
    @(posedge clk);
    #1;
    if1.in_valid = 1'b1; if1.a = 255; if1.b = 0; if1.re = 1'b1; if1.reb = 1'b0; if1.eq = 1'b0;
    exp_rdy = 1;
    repeat (6) begin
      @(negedge clk);
      chk("w1_in_ready_toggle", if1.in_ready, exp_rdy);
      chk("w1_out_valid_toggle", if1.out_valid, 1 - exp_rdy);
      if (if1.in_ready) q1.push_back(mk(1, 0, 0, 255));
      exp_rdy = 1 - exp_rdy;
    end
    @(posedge clk);
    #1 if1.in_valid = 1'b0;
    q1.push_back(mk(0, 1, 0, 7));
    send1(0, 7, 0, 1, 0);
    q1.push_back(mk(0, 0, 1, 3));
    send1(3, 3, 0, 0, 1);
    drain();

    // Random operands with a correct reference comparator.
    for (int w = 0; w < 100; w++) begin
      g = 0; l = 0; e = 0; m = 0;
      for (int i = 0; i < 4; i++) begin
        ra[i] = 8'($urandom_range(0, 255));
        rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 8'($urandom_range(0, 255));
        if (ra[i] > rb[i]) g++;
        else if (ra[i] < rb[i]) l++;
        else e++;
        if (int'(ra[i]) > m) m = int'(ra[i]);
        if (int'(rb[i]) > m) m = int'(rb[i]);
      end
      q4.push_back(mk(g, l, e, m));
      for (int i = 0; i < 4; i++)
        send4(ra[i], rb[i], ra[i] > rb[i], ra[i] < rb[i], ra[i] == rb[i]);
    end
    drain();
    chk("err_after_random", if4.err, 0);

`ifdef COMPARE8_CHECK_EN
    // Inconsistent flags: counted as given, err latches until reset.
    q4.push_back(mk(1, 0, 3, 9));
    send4(4, 9, 1, 0, 0);
    @(negedge clk);
    chk("err_set", if4.err, 1);
    repeat (3) send4(1, 1, 0, 0, 1);
    q4.push_back(mk(0, 0, 4, 8));
    repeat (4) send4(8, 8, 0, 0, 1);
    drain();
    chk("err_sticky", if4.err, 1);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", if4.err, 0);
`else
    q4.push_back(mk(1, 0, 3, 9));
    send4(4, 9, 1, 0, 0);
    @(negedge clk);
    chk("err_tied_low", if4.err, 0);
    repeat (3) send4(1, 1, 0, 0, 1);
    drain();
    chk("err_tied_low_end", if4.err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
